xif_commit_result_ctrl: RTL and testbench

- Downstream companion to the CV-X-IF coprocessor issue stage.
- Records every issue transaction the coprocessor accepts, tracks the commit/kill outcome of each, and drives the result interface in issue order.
- Each committed instruction writes back a 32-bit signature value to its destination register.
- Each killed instruction is retired silently.

---
 rtl/xif_trk_pkg.sv | 16 +
 rtl/xif_trk_table.sv | 79 +++++++
 rtl/xif_commit_result_ctrl.sv | 112 +++++++++++
 tb/tb_xif_commit_result_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/xif_trk_pkg.sv
// Shared types for the CV-X-IF commit/result tracker.
// Optional result/kill counters in the top are enabled by defining XIF_RESULT_CNT_EN.
package xif_trk_pkg;
  localparam int RD_WIDTH = 5;
  // Entries store IDs zero-extended to this width; X_ID_WIDTH must not exceed it.
  localparam int ID_MAX_W = 16;

  typedef enum logic [1:0] {FREE, PENDING, COMMITTED, KILLED} entry_state_e;
  typedef enum logic {IDLE, RESULT} out_state_e;

  typedef struct packed {
    logic [ID_MAX_W-1:0] id;
    logic [RD_WIDTH-1:0] rd;
    entry_state_e        state;
  } entry_t;
endpackage

// File: rtl/xif_trk_table.sv
// In-order table of issued instructions: push at wptr, ID-matched commit update,
// pop at rptr. Head/next views reflect this cycle's push and commit.
module xif_trk_table
  import xif_trk_pkg::*;
#(
  parameter int X_ID_WIDTH = 4,
  parameter int DEPTH      = 4,
  localparam int PW        = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push,
  input  logic [X_ID_WIDTH-1:0] push_id,
  input  logic [RD_WIDTH-1:0]   push_rd,
  input  logic                  commit,
  input  logic [X_ID_WIDTH-1:0] commit_id,
  input  logic                  commit_kill,
  input  logic                  pop,
  output logic                  commit_hit,
  output logic [X_ID_WIDTH-1:0] head_id,
  output logic [RD_WIDTH-1:0]   head_rd,
  output entry_state_e          head_state,
  output logic [X_ID_WIDTH-1:0] nxt_id,
  output logic [RD_WIDTH-1:0]   nxt_rd,
  output entry_state_e          nxt_state,
  output logic                  full,
  output logic [PW:0]           count
);
  entry_t        ent [DEPTH];
  entry_t        eff [DEPTH];
  logic [PW-1:0] wptr, rptr, rptr_inc;
  logic          push_ok;

  assign full     = (count == (PW+1)'(DEPTH));
  assign push_ok  = push && !full;
  assign rptr_inc = rptr + 1'b1;

  // eff is the table as it will look after this edge, before the pop.
  always_comb begin
    eff = ent;
    commit_hit = 1'b0;
    if (push_ok) eff[wptr] = '{id: ID_MAX_W'(push_id), rd: push_rd, state: PENDING};
    if (commit) begin
      if (push_ok && push_id == commit_id) begin
        eff[wptr].state = commit_kill ? KILLED : COMMITTED;
        commit_hit = 1'b1;
      end else begin
        for (int i = 0; i < DEPTH; i++) begin
          if (!commit_hit && ent[i].state == PENDING && ent[i].id == ID_MAX_W'(commit_id)) begin
            eff[i].state = commit_kill ? KILLED : COMMITTED;
            commit_hit = 1'b1;
          end
        end
      end
    end
  end

  assign head_id    = eff[rptr].id[X_ID_WIDTH-1:0];
  assign head_rd    = eff[rptr].rd;
  assign head_state = eff[rptr].state;
  assign nxt_id     = eff[rptr_inc].id[X_ID_WIDTH-1:0];
  assign nxt_rd     = eff[rptr_inc].rd;
  assign nxt_state  = eff[rptr_inc].state;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) ent[i] <= '0;
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      ent <= eff;
      if (pop) ent[rptr].state <= FREE;
      if (push_ok) wptr <= wptr + 1'b1;
      if (pop) rptr <= rptr_inc;
      count <= count + (PW+1)'(push_ok) - (PW+1)'(pop);
    end
  end
endmodule

// File: rtl/xif_commit_result_ctrl.sv
// Tracks accepted CV-X-IF issues and drives the result interface in issue order.
// Define XIF_RESULT_CNT_EN to add the res_cnt_o / kill_cnt_o counters.
module xif_commit_result_ctrl
  import xif_trk_pkg::*;
#(
  parameter int X_ID_WIDTH  = 4,
  parameter int DEPTH       = 4,
  parameter int X_RFW_WIDTH = 32
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   issue_valid_i,
  input  logic                   issue_ready_i,
  input  logic                   issue_accept_i,
  input  logic [X_ID_WIDTH-1:0]  issue_id_i,
  input  logic [4:0]             issue_rd_i,
  output logic                   issue_stall_o,
  input  logic                   commit_valid_i,
  input  logic [X_ID_WIDTH-1:0]  commit_id_i,
  input  logic                   commit_kill_i,
  input  logic [X_RFW_WIDTH-1:0] sig_i,
  output logic                   result_valid_o,
  input  logic                   result_ready_i,
  output logic [X_ID_WIDTH-1:0]  result_id_o,
  output logic [4:0]             result_rd_o,
  output logic [X_RFW_WIDTH-1:0] result_data_o,
  output logic                   result_we_o,
  output logic                   busy_o,
  output logic                   err_o
`ifdef XIF_RESULT_CNT_EN
  ,
  output logic [31:0]            res_cnt_o,
  output logic [31:0]            kill_cnt_o
`endif
);
  localparam int PW = $clog2(DEPTH);

  out_state_e            state;
  logic                  push_req, pop, pop_kill, hs, commit_hit, full;
  logic [X_ID_WIDTH-1:0] head_id, nxt_id;
  logic [RD_WIDTH-1:0]   head_rd, nxt_rd;
  entry_state_e          head_state, nxt_state;
  logic [PW:0]           count;

  assign push_req      = issue_valid_i && issue_ready_i && issue_accept_i;
  assign pop_kill      = (state == IDLE) && (head_state == KILLED);
  assign hs            = (state == RESULT) && result_ready_i;
  assign pop           = pop_kill || hs;
  assign issue_stall_o = full;
  assign busy_o        = (count != '0);

  xif_trk_table #(.X_ID_WIDTH(X_ID_WIDTH), .DEPTH(DEPTH)) u_table (
    .clk_i, .rst_ni,
    .push(push_req), .push_id(issue_id_i), .push_rd(issue_rd_i),
    .commit(commit_valid_i), .commit_id(commit_id_i), .commit_kill(commit_kill_i),
    .pop, .commit_hit,
    .head_id, .head_rd, .head_state, .nxt_id, .nxt_rd, .nxt_state,
    .full, .count
  );

  // Head views include this cycle's commit, so a head commit shows up one cycle later.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state          <= IDLE;
      result_valid_o <= 1'b0;
      result_id_o    <= '0;
      result_rd_o    <= '0;
      result_data_o  <= '0;
      result_we_o    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (head_state == COMMITTED) begin
          result_valid_o <= 1'b1;
          result_id_o    <= head_id;
          result_rd_o    <= head_rd;
          result_data_o  <= sig_i;
          result_we_o    <= 1'b1;
          state          <= RESULT;
        end
        RESULT: if (result_ready_i) begin
          if (nxt_state == COMMITTED) begin
            result_id_o   <= nxt_id;
            result_rd_o   <= nxt_rd;
            result_data_o <= sig_i;
            result_we_o   <= 1'b1;
          end else begin
            result_valid_o <= 1'b0;
            state          <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) err_o <= 1'b0;
    else if ((push_req && full) || (commit_valid_i && !commit_hit)) err_o <= 1'b1;
  end

`ifdef XIF_RESULT_CNT_EN
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      res_cnt_o  <= '0;
      kill_cnt_o <= '0;
    end else begin
      if (hs) res_cnt_o <= res_cnt_o + 32'd1;
      if (pop_kill) kill_cnt_o <= kill_cnt_o + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_xif_commit_result_ctrl.sv
// Self-checking bench: vector table, directed corner sequences, and a random
// run scored against an issue-order queue model.
module tb_xif_commit_result_ctrl;
  logic        clk = 1'b0, rst_n;
  logic        issue_valid, issue_ready, issue_accept, commit_valid, commit_kill, result_ready;
  logic [3:0]  issue_id, commit_id, result_id;
  logic [4:0]  issue_rd, result_rd;
  logic [31:0] sig, result_data;
  logic        issue_stall, result_valid, result_we, busy, err;
`ifdef XIF_RESULT_CNT_EN
  logic [31:0] res_cnt, kill_cnt;
`endif

  int checks = 0, errors = 0;

  xif_commit_result_ctrl #(.X_ID_WIDTH(4), .DEPTH(4), .X_RFW_WIDTH(32)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .issue_valid_i(issue_valid), .issue_ready_i(issue_ready), .issue_accept_i(issue_accept),
    .issue_id_i(issue_id), .issue_rd_i(issue_rd), .issue_stall_o(issue_stall),
    .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
    .sig_i(sig), .result_valid_o(result_valid), .result_ready_i(result_ready),
    .result_id_o(result_id), .result_rd_o(result_rd), .result_data_o(result_data),
    .result_we_o(result_we), .busy_o(busy), .err_o(err)
`ifdef XIF_RESULT_CNT_EN
    , .res_cnt_o(res_cnt), .kill_cnt_o(kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic idle_in;
    issue_valid = 0; issue_ready = 0; issue_accept = 0; issue_id = 0; issue_rd = 0;
    commit_valid = 0; commit_id = 0; commit_kill = 0; sig = 0; result_ready = 0;
  endtask

  task automatic do_reset;
    idle_in;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    tick;
  endtask

  task automatic issue(input logic [3:0] id, input logic [4:0] rd);
    issue_valid = 1; issue_ready = 1; issue_accept = 1; issue_id = id; issue_rd = rd;
    tick;
    issue_valid = 0; issue_ready = 0; issue_accept = 0;
  endtask

  task automatic commit(input logic [3:0] id, input logic kill, input logic [31:0] s);
    commit_valid = 1; commit_id = id; commit_kill = kill; sig = s;
    tick;
    commit_valid = 0;
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic iv; logic [3:0] iid; logic [4:0] ird;
    logic cv; logic [3:0] cid; logic ck; logic [31:0] s;
    logic e_vld; logic [3:0] e_id; logic [4:0] e_rd; logic [31:0] e_data;
    logic e_busy; logic e_err; logic chk_res;
  } vec_t;
  vec_t vt[$];

  function automatic vec_t mk(logic iv, logic [3:0] iid, logic [4:0] ird, logic cv, logic [3:0] cid,
                              logic ck, logic [31:0] s, logic ev, logic [3:0] eid, logic [4:0] erd,
                              logic [31:0] ed, logic eb, logic ee, logic cr);
    vec_t v;
    v.iv = iv; v.iid = iid; v.ird = ird; v.cv = cv; v.cid = cid; v.ck = ck; v.s = s;
    v.e_vld = ev; v.e_id = eid; v.e_rd = erd; v.e_data = ed; v.e_busy = eb; v.e_err = ee; v.chk_res = cr;
    return v;
  endfunction

  // ---------------- random model ----------------
  typedef struct { logic [3:0] id; logic [4:0] rd; int seq; int st; } me_t; // st: 0 pending, 1 committed
  me_t mq[$];
  int  seqn = 0;
  logic        hold_v = 0;
  logic [3:0]  hold_id;
  logic [4:0]  hold_rd;
  logic [31:0] hold_data;

  function automatic logic [31:0] sigf(me_t e);
    logic [31:0] sq;
    sq = e.seq;
    return {8'h51, 4'h0, e.id, sq[15:0]};
  endfunction

  function automatic bit id_used(logic [3:0] id);
    foreach (mq[i]) if (mq[i].id == id) return 1;
    return 0;
  endfunction

  task automatic rand_cycle(input bit drain);
    int pend[$];
    logic [3:0] nid;
    idle_in;
    if (hold_v) begin
      chk("rand_hold_vld", result_valid, 1'b1);
      chk("rand_hold_res", {result_id, result_rd, result_data}, {hold_id, hold_rd, hold_data});
    end
    result_ready = drain ? 1'b1 : ($urandom_range(9) < 7);
    if (result_valid && result_ready) begin
      if (mq.size() == 0 || mq[0].st != 1) begin
        chk("rand_unexpected_result", {result_id, result_rd}, 0);
        chk("rand_unexpected_valid", result_valid, 1'b0);
      end else begin
        chk("rand_result", {result_id, result_rd, result_data, result_we},
            {mq[0].id, mq[0].rd, sigf(mq[0]), 1'b1});
        void'(mq.pop_front());
      end
    end
    hold_v = result_valid && !result_ready;
    hold_id = result_id; hold_rd = result_rd; hold_data = result_data;
    if (!drain && !issue_stall && $urandom_range(2) == 0) begin
      do nid = 4'($urandom_range(15)); while (id_used(nid));
      issue_valid = 1; issue_ready = 1; issue_accept = ($urandom_range(4) != 0);
      issue_id = nid; issue_rd = 5'($urandom_range(31));
      if (issue_accept) begin
        mq.push_back('{id: nid, rd: issue_rd, seq: seqn, st: 0});
        seqn++;
      end
    end
    foreach (mq[i]) if (mq[i].st == 0) pend.push_back(i);
    if (pend.size() > 0 && (drain || $urandom_range(2) == 0)) begin
      int k;
      k = pend[$urandom_range(pend.size() - 1)];
      commit_valid = 1; commit_id = mq[k].id; commit_kill = ($urandom_range(3) == 0);
      if (commit_kill) mq.delete(k);
      else mq[k].st = 1;
    end
    sig = (mq.size() > 0 && mq[0].st == 1) ? sigf(mq[0]) : $urandom;
    tick;
  endtask

  initial begin
    int n, ids[$];
    bit seen;
    idle_in;
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_outputs", {result_valid, result_id, result_rd, result_data, result_we, busy, err, issue_stall}, 0);
    rst_n = 1;
    tick;

    // single instruction, kill, bad commit (ready held high)
    vt.push_back(mk(1,3,5, 0,0,0,0,             0,0,0,0,             1,0,0));
    vt.push_back(mk(0,0,0, 0,0,0,0,             0,0,0,0,             1,0,0));
    vt.push_back(mk(0,0,0, 1,3,0,32'hDEADBEEF,  1,3,5,32'hDEADBEEF,  1,0,1));
    vt.push_back(mk(0,0,0, 0,0,0,32'h12345678,  0,0,0,0,             0,0,0));
    vt.push_back(mk(0,0,0, 0,0,0,0,             0,0,0,0,             0,0,0));
    vt.push_back(mk(1,1,1, 0,0,0,0,             0,0,0,0,             1,0,0));
    vt.push_back(mk(1,2,2, 0,0,0,0,             0,0,0,0,             1,0,0));
    vt.push_back(mk(0,0,0, 1,1,1,32'h11111111,  0,0,0,0,             1,0,0));
    vt.push_back(mk(0,0,0, 1,2,0,32'h22222222,  1,2,2,32'h22222222,  1,0,1));
    vt.push_back(mk(0,0,0, 0,0,0,0,             0,0,0,0,             0,0,0));
    vt.push_back(mk(0,0,0, 1,9,0,0,             0,0,0,0,             0,1,0));
    vt.push_back(mk(0,0,0, 0,0,0,0,             0,0,0,0,             0,1,0));
    foreach (vt[i]) begin
      issue_valid = vt[i].iv; issue_ready = vt[i].iv; issue_accept = vt[i].iv;
      issue_id = vt[i].iid; issue_rd = vt[i].ird;
      commit_valid = vt[i].cv; commit_id = vt[i].cid; commit_kill = vt[i].ck;
      sig = vt[i].s; result_ready = 1;
      tick;
      chk($sformatf("vec%0d_vld", i), result_valid, vt[i].e_vld);
      chk($sformatf("vec%0d_busy_err_stall", i), {busy, err, issue_stall}, {vt[i].e_busy, vt[i].e_err, 1'b0});
      if (vt[i].chk_res)
        chk($sformatf("vec%0d_res", i), {result_id, result_rd, result_data, result_we},
            {vt[i].e_id, vt[i].e_rd, vt[i].e_data, 1'b1});
    end

    // out-of-order commit, in-order back-to-back results
    do_reset;
    result_ready = 1;
    issue(4, 4); issue(5, 5); issue(6, 6);
    commit(6, 0, 32'h66); commit(5, 0, 32'h55);
    commit(4, 0, 32'h44);
    chk("ooo_first", {result_valid, result_id, result_data}, {1'b1, 4'd4, 32'h44});
    sig = 32'h555; tick;
    chk("ooo_second", {result_valid, result_id, result_rd, result_data}, {1'b1, 4'd5, 5'd5, 32'h555});
    sig = 32'h666; tick;
    chk("ooo_third", {result_valid, result_id, result_rd, result_data}, {1'b1, 4'd6, 5'd6, 32'h666});
    tick;
    chk("ooo_done", {result_valid, busy}, 0);

    // backpressure with a bad commit during the stall
    do_reset;
    issue(7, 9);
    commit(7, 0, 32'h77);
    chk("bp_load", {result_valid, result_id, result_rd, result_data}, {1'b1, 4'd7, 5'd9, 32'h77});
    for (int c = 0; c < 5; c++) begin
      sig = $urandom;
      if (c == 2) begin commit_valid = 1; commit_id = 9; end
      tick;
      commit_valid = 0;
      chk($sformatf("bp_hold%0d", c), {result_valid, result_id, result_rd, result_data, result_we},
          {1'b1, 4'd7, 5'd9, 32'h77, 1'b1});
    end
    chk("bp_err", err, 1'b1);
    result_ready = 1;
    tick;
    chk("bp_handshake", {result_valid, busy}, 0);

    // full table, forced fifth push
    do_reset;
    for (int i = 0; i < 4; i++) issue(4'(i), 5'(i + 10));
    chk("full_stall", {issue_stall, busy, err}, 3'b110);
    issue(8, 20);
    chk("full_drop_err", {issue_stall, err}, 2'b11);
    result_ready = 1; n = 0; ids.delete();
    for (int c = 0; c < 30; c++) begin
      if (c < 4) begin commit_valid = 1; commit_id = 4'(c); commit_kill = 0; end
      else commit_valid = 0;
      sig = 32'hF0 + c;
      tick;
      if (result_valid) begin n++; ids.push_back(int'(result_id)); end
    end
    chk("full_result_count", n, 4);
    for (int i = 0; i < 4 && i < ids.size(); i++) chk($sformatf("full_order%0d", i), ids[i], i);
    chk("full_drained", {busy, issue_stall}, 0);

    // reset while a result is pending
    do_reset;
    issue(5, 7);
    commit(5, 0, 32'hABCD);
    commit(12, 0, 0);
    chk("rst_pre", {result_valid, err, busy}, 3'b111);
    #2 rst_n = 0;
    #1 chk("rst_async", {result_valid, busy, err, issue_stall}, 0);
    @(posedge clk); #1 rst_n = 1;
    result_ready = 1; seen = 0;
    for (int c = 0; c < 6; c++) begin tick; if (result_valid || busy) seen = 1; end
    chk("rst_no_stale", seen, 0);

    // randomized run against the queue model, then drain
    do_reset;
    mq.delete(); hold_v = 0;
    for (int c = 0; c < 1500; c++) rand_cycle(0);
    n = 0;
    while (!(mq.size() == 0 && !busy && !result_valid) && n < 300) begin rand_cycle(1); n++; end
    chk("rand_drain_timeout", n < 300, 1'b1);
    chk("rand_final", {busy, err, result_valid}, 0);
    chk("rand_model_empty", mq.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
